// File: rtl/rr_lane_fifo.sv
// Round-robin collector: merges per-channel multi-lane words into one tagged FWFT FIFO.
// Optional X/Z detection on pushed words is enabled by defining RR_LANE_FIFO_XCHECK_EN.
module rr_lane_fifo #(
    parameter int CHANNELS = 4,
    parameter int LANES    = 4,
    parameter int LANE_W   = 5,
    parameter int DEPTH    = 8,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [CHANNELS-1:0]                    in_valid,
    output logic [CHANNELS-1:0]                    in_ready,
    input  logic [CHANNELS-1:0][LANES-1:0][LANE_W-1:0] in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LANES-1:0][LANE_W-1:0]           out_data,
    output logic [CW-1:0]                          out_chan,
    output logic [AW:0]                            count,
    output logic                                   xz_err
);

    logic [AW:0]                      r_count;
    logic [AW-1:0]                    r_wr_ptr;
    logic [AW-1:0]                    r_rd_ptr;
    logic [CW-1:0]                    r_rr_ptr;
    logic [LANES-1:0][LANE_W-1:0]     r_mem_data [DEPTH];
    logic [CW-1:0]                    r_mem_chan [DEPTH];

    logic                             w_empty;
    logic                             w_full;
    logic                             w_pop;
    logic                             w_space;
    logic                             w_grant_vld;
    logic [CW-1:0]                    w_grant_idx;
    logic                             w_push;
    logic [CW-1:0]                    w_rr_next;
    logic [CHANNELS-1:0]              w_ready;
    logic [LANES-1:0][LANE_W-1:0]     w_push_data;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_space = !w_full || w_pop;

    always_comb begin
        int idx;
        idx         = 0;
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_grant_vld && in_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CW'(idx);
            end
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held.
    assign w_push      = w_grant_vld && w_space && rst_n;
    assign w_push_data = in_data[w_grant_idx];
    assign w_rr_next   = (w_grant_idx == CW'(CHANNELS - 1)) ? '0 : w_grant_idx + CW'(1);

    always_comb begin
        w_ready = '0;
        if (w_push) begin
            w_ready[w_grant_idx] = 1'b1;
        end
    end

    assign in_ready = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_rr_ptr <= w_rr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_chan[r_wr_ptr] <= w_grant_idx;
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
    assign out_chan  = w_empty ? '0 : r_mem_chan[r_rd_ptr];
    assign count     = r_count;

`ifdef RR_LANE_FIFO_XCHECK_EN
    logic r_xz_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xz_err <= 1'b0;
        end else if (w_push && ((^w_push_data) === 1'bx)) begin
            r_xz_err <= 1'b1;
        end
    end

    assign xz_err = r_xz_err;
`else
    assign xz_err = 1'b0;
`endif

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
    a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) r_count <= (AW+1)'(DEPTH));

endmodule

// File: tb/tb_rr_lane_fifo.sv
// Directed bench for rr_lane_fifo: reset, fairness, fill/full, wrap, async reset, X/Z flag.
module tb_rr_lane_fifo;

    localparam int CH = 4;
    localparam int LN = 4;
    localparam int LW = 5;
    localparam int DP = 8;

    typedef logic [LN-1:0][LW-1:0] word_t;

    logic                 clk;
    logic                 rst_n;
    logic [CH-1:0]        in_valid;
    logic [CH-1:0]        in_ready;
    logic [CH-1:0][LN-1:0][LW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    word_t                out_data;
    logic [1:0]           out_chan;
    logic [3:0]           count;
    logic                 xz_err;

    int n_vec = 0;
    int n_err = 0;

    rr_lane_fifo #(.CHANNELS(CH), .LANES(LN), .LANE_W(LW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan),
        .count(count), .xz_err(xz_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Channel c in the fairness test: lane l carries c*4+l+1.
    function automatic word_t chan_word(input int c);
        word_t w;
        for (int l = 0; l < LN; l++) w[l] = LW'(c * 4 + l + 1);
        return w;
    endfunction

    function automatic word_t all_lanes(input int v);
        word_t w;
        for (int l = 0; l < LN; l++) w[l] = LW'(v);
        return w;
    endfunction

    function automatic word_t seq_word(input int i);
        word_t w;
        for (int l = 0; l < LN; l++) w[l] = LW'((i * 7 + l * 3 + 3) & 31);
        return w;
    endfunction

    word_t q[$];
    word_t xw;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int c = 0; c < CH; c++) in_data[c] = chan_word(c);

        // Reset held with every channel requesting
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_count", 64'(count), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_chan", 64'(out_chan), 64'h0);
        check("rst_xz_err", 64'(xz_err), 64'h0);

        // Fairness: all valid, consumer always ready
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_grant", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check("fair_chan", 64'(out_chan), 64'((k - 1) % 4));
                check("fair_data", 64'(out_data), 64'(chan_word((k - 1) % 4)));
                check("fair_count", 64'(count), 64'd1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = '0;
        @(posedge clk);

        // Fill from channel 2 with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        for (int v = 0; v <= 8; v++) begin
            in_data[2] = all_lanes(v);
            #1;
            check("fill_ready", 64'(in_ready), (v < 8) ? 64'h4 : 64'h0);
            check("fill_count", 64'(count), 64'(v));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("full_valid", 64'(out_valid), 64'h1);
        check("full_head", 64'(out_data), 64'(all_lanes(0)));
        check("full_chan", 64'(out_chan), 64'h2);

        // Full with simultaneous push and pop
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            in_data[2] = all_lanes(8 + j);
            #1;
            check("fullpp_ready", 64'(in_ready), 64'h4);
            check("fullpp_count", 64'(count), 64'd8);
            check("fullpp_data", 64'(out_data), 64'(all_lanes(j)));
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = '0;
        for (int j = 4; j < 12; j++) begin
            #1;
            check("drain_data", 64'(out_data), 64'(all_lanes(j)));
            check("drain_count", 64'(count), 64'(12 - j));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("drain_empty", 64'(count), 64'h0);
        check("drain_zero", 64'(out_data), 64'h0);

        // Wrap: 20 words through channel 1 with pseudo-random consumer stalls
        begin
            int sent;
            int rcvd;
            int cyc;
            sent = 0;
            rcvd = 0;
            cyc  = 0;
            q.delete();
            while (rcvd < 20 && cyc < 400) begin
                @(negedge clk);
                in_valid   = (sent < 20) ? 4'b0010 : 4'b0000;
                in_data[1] = seq_word(sent);
                out_ready  = 1'($urandom_range(0, 2) != 0);
                #1;
                check("wrap_count", 64'(count), 64'(q.size()));
                if (out_valid && out_ready) begin
                    check("wrap_data", 64'(out_data), 64'(q[0]));
                    check("wrap_chan", 64'(out_chan), 64'h1);
                    void'(q.pop_front());
                    rcvd++;
                end
                if (in_ready[1]) begin
                    q.push_back(seq_word(sent));
                    sent++;
                end
                @(posedge clk);
                cyc++;
            end
            check("wrap_done", 64'(rcvd), 64'd20);
        end

        // Mid-operation asynchronous reset with 5 entries held
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            in_data[0] = all_lanes(20 + i);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("mid_count5", 64'(count), 64'd5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_count0", 64'(count), 64'h0);
        check("mid_valid0", 64'(out_valid), 64'h0);
        check("mid_ready0", 64'(in_ready), 64'h0);
        in_valid = '0;
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        check("mid_after_cnt", 64'(count), 64'h0);
        check("mid_after_data", 64'(out_data), 64'h0);
        in_valid   = 4'b0001;
        in_data[0] = all_lanes(30);
        @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        #1;
        check("mid_new_data", 64'(out_data), 64'(all_lanes(30)));
        check("mid_new_count", 64'(count), 64'd1);

        // Word with lane 1 = 5'b0x000
        out_ready  = 1'b1;
        xw         = all_lanes(1);
        xw[1]      = 5'b0x000;
        in_data[3] = xw;
        in_valid   = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        #1;
`ifdef RR_LANE_FIFO_XCHECK_EN
        check("xz_set", 64'(xz_err), 64'h1);
`else
        check("xz_off", 64'(xz_err), 64'h0);
`endif
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
`ifdef RR_LANE_FIFO_XCHECK_EN
        check("xz_held", 64'(xz_err), 64'h1);
`else
        check("xz_off_held", 64'(xz_err), 64'h0);
`endif
        check("final_empty", 64'(count), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
